// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - front-end redirect arbiter, wrong-path kill and drain sequencer
module fetch_redirect_ctrl #(
  parameter int PC_W    = 64,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_ena,
  input  logic [PC_W-1:0] trap_pc,
  input  logic            bru_ena,
  input  logic [PC_W-1:0] bru_pc,
  input  logic            decode1_ena,
  input  logic [PC_W-1:0] decode1_pc,
  input  logic            decode2_ena,
  input  logic [PC_W-1:0] decode2_pc,
  input  logic            fetch_req_valid,
  output logic            fetch_req_ready,
  input  logic            fetch_resp_valid,
  output logic            resp_kill,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            busy,
  output logic [15:0]     redirect_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  localparam logic [1:0] LVL_TRAP = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic [1:0]      pend_lvl_q, pend_lvl_d;
  logic [15:0]     redirect_cnt_q, redirect_cnt_d;

  logic            any_en;
  logic [1:0]      win_lvl;
  logic [PC_W-1:0] win_pc;
  logic            req_fire;
  logic            resp_dec;
  logic [CNT_W-1:0] kill_base;
  logic            handshake;
  logic            override;

  // Fixed-priority pick of the highest-level redirect source this cycle
  always_comb begin
    win_lvl = 2'd0;
    win_pc  = decode2_pc;
    if (trap_ena) begin
      win_lvl = 2'd3;
      win_pc  = trap_pc;
    end else if (bru_ena) begin
      win_lvl = 2'd2;
      win_pc  = bru_pc;
    end else if (decode1_ena) begin
      win_lvl = 2'd1;
      win_pc  = decode1_pc;
    end
  end

  assign any_en    = trap_ena | bru_ena | decode1_ena | decode2_ena;
  assign fetch_req_ready = (state_q == ST_IDLE) && !any_en &&
                           (out_cnt_q < CNT_W'(MAX_OUT));
  assign req_fire  = fetch_req_valid && fetch_req_ready;
  // A response with nothing outstanding is a protocol error; never underflow
  assign resp_dec  = fetch_resp_valid && (out_cnt_q != '0);
  assign kill_base = out_cnt_q - CNT_W'(resp_dec);
  assign resp_kill = fetch_resp_valid && (kill_cnt_q != '0);
  assign handshake = (state_q == ST_ISSUE) && redirect_ready;
  // Strictly higher level wins; a newer trap also replaces a pending trap
  assign override  = any_en && ((win_lvl > pend_lvl_q) ||
                                (trap_ena && (pend_lvl_q == LVL_TRAP)));

  // Outstanding fetch count: request adds, response removes
  always_comb begin
    out_cnt_d = out_cnt_q;
    if (req_fire && !resp_dec) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end else if (!req_fire && resp_dec) begin
      out_cnt_d = out_cnt_q - CNT_W'(1);
    end
  end

  // Redirect sequencing: capture, drain wrong-path responses, then present target
  always_comb begin
    state_d        = state_q;
    pend_pc_d      = pend_pc_q;
    pend_lvl_d     = pend_lvl_q;
    kill_cnt_d     = resp_kill ? (kill_cnt_q - CNT_W'(1)) : kill_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_en) begin
          pend_pc_d  = win_pc;
          pend_lvl_d = win_lvl;
          kill_cnt_d = kill_base;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (override) begin
          pend_pc_d  = win_pc;
          pend_lvl_d = win_lvl;
        end
        // Look at next-cycle counts so ISSUE follows the last response directly
        if ((kill_cnt_d == '0) && (out_cnt_d == '0)) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (handshake) begin
          if (redirect_cnt_q != 16'hFFFF) begin
            redirect_cnt_d = redirect_cnt_q + 16'd1;
          end
          if (any_en) begin
            pend_pc_d  = win_pc;
            pend_lvl_d = win_lvl;
            kill_cnt_d = kill_base;
            state_d    = ST_DRAIN;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (override) begin
          pend_pc_d  = win_pc;
          pend_lvl_d = win_lvl;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers; reset discards any pending redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      out_cnt_q      <= '0;
      kill_cnt_q     <= '0;
      pend_pc_q      <= '0;
      pend_lvl_q     <= 2'd0;
      redirect_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      out_cnt_q      <= out_cnt_d;
      kill_cnt_q     <= kill_cnt_d;
      pend_pc_q      <= pend_pc_d;
      pend_lvl_q     <= pend_lvl_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign redirect_valid = (state_q == ST_ISSUE);
  assign redirect_pc    = pend_pc_q;
  assign redirect_cnt   = redirect_cnt_q;

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Sequences front-end redirects between the fetch PC register and the instruction cache. It arbitrates simultaneous redirect requests from trap, branch unit and the two decode slots, and stalls new fetch issue. It kills in-flight cache responses from the wrong path and drains the cache before handing the winning target to the PC register with a valid/ready handshake. It sits between the redirect sources and the PC/icache request path.

## Interface
- PC_W, 64, width of all PC buses
- MAX_OUT, 4, maximum outstanding icache fetches (2..15)
- CNT_W, 4, width of outstanding/kill counters; must hold MAX_OUT

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- trap_ena / trap_pc  in  1 / PC_W  trap or exception redirect, level 3
- bru_ena / bru_pc  in  1 / PC_W  execute-stage mispredict redirect, level 2
- decode1_ena / decode1_pc  in  1 / PC_W  decode slot 1 redirect, level 1
- decode2_ena / decode2_pc  in  1 / PC_W  decode slot 2 redirect, level 0
- fetch_req_valid  in  1  PC register wants to issue a fetch
- fetch_req_ready  out  1  fetch may issue this cycle
- fetch_resp_valid  in  1  icache returns one fetch packet
- resp_kill  out  1  current response is wrong-path; decode must drop it
- redirect_valid  out  1  redirect target presented to PC register
- redirect_pc  out  PC_W  redirect target
- redirect_ready  in  1  PC register accepts target
- busy  out  1  state != IDLE
- redirect_cnt  out  16  accepted redirects, saturating at 16'hFFFF

## Operation
- The controller has three states: IDLE, DRAIN and ISSUE.
- Any enable: the winner is the highest level present. trap beats bru, bru beats decode1, decode1 beats decode2.
- Outstanding counter out_cnt:
  - +1 on fetch_req_valid && fetch_req_ready.
  - −1 on fetch_resp_valid.
  - Both in the same cycle leave it unchanged.
  - A response with out_cnt==0 is a protocol error; the counter does not underflow and holds 0.
- fetch_req_ready = (state==IDLE) && no redirect enable this cycle && out_cnt < MAX_OUT.
- IDLE + any enable, at the edge:
  - Capture pend_pc/pend_lvl from the winner.
  - kill_cnt <= out_cnt − fetch_resp_valid.
  - Go to DRAIN.
- resp_kill = fetch_resp_valid && kill_cnt != 0. Each killed response decrements kill_cnt.
- DRAIN:
  - Exit when kill_cnt==0 and out_cnt==0; go to ISSUE on the next edge.
  - If both are already 0 at capture, DRAIN lasts exactly one cycle.
- ISSUE:
  - redirect_valid=1 and redirect_pc=pend_pc, held stable until redirect_ready.
  - On the handshake: go to IDLE and increment redirect_cnt.
- Override in DRAIN or ISSUE:
  - A new enable with level > pend_lvl replaces pend_pc/pend_lvl.
  - trap_ena also replaces an equal-level pending trap; the newest trap wins.
  - Lower or equal non-trap requests are ignored.
  - An override in ISSUE without a handshake stays in ISSUE; the new pc is visible from the next cycle.
- Handshake plus a new enable in the same cycle:
  - The handshake completes and redirect_cnt increments.
  - The new request is captured and the state goes to DRAIN, with kill_cnt = out_cnt − fetch_resp_valid (0 in practice).
- Reset values:
  - state = IDLE; out_cnt, kill_cnt, pend_lvl and redirect_cnt = 0; pend_pc = 0.
  - Outputs: redirect_valid=0, resp_kill=0, busy=0, redirect_pc=0. fetch_req_ready is 1 unless fetch is blocked by out_cnt or a redirect enable.
- Reset mid-DRAIN or mid-ISSUE discards the pending redirect. The counters clear, and responses arriving afterward are not killed.

## Timing
- Redirect enable at cycle T:
  - fetch_req_ready drops combinationally in T.
  - busy=1 from T+1.
  - With nothing outstanding, redirect_valid=1 at T+2.
- Each outstanding response extends DRAIN by the cycles until its return. resp_kill is combinational in the same cycle as fetch_resp_valid.
- redirect_pc is registered; no combinational path exists from redirect inputs to redirect_pc.
- After the handshake at cycle H, fetch_req_ready may be 1 at H+1.

## Test plan
- trap_ena, trap_pc=0x80000100, out_cnt=0 at T → redirect_valid at T+2 with redirect_pc=0x80000100; redirect_ready at T+2 → busy=0 at T+3 and redirect_cnt=1.
- decode2_ena (0x80000040) and bru_ena (0x80000200) together in one cycle → redirect_pc=0x80000200.
- 3 fetches outstanding, then decode1 redirect → next 3 responses have resp_kill=1; ISSUE in the cycle after the third; the 4th response (new path) has resp_kill=0.
- Pending decode1 in DRAIN, then trap_ena 0x80000004 → redirect_pc=0x80000004. Pending bru, then decode1 → pc unchanged.
- out_cnt=MAX_OUT → fetch_req_ready=0. A response with no new request → ready=1 next cycle. Request and response in the same cycle → out_cnt unchanged.
- rst asserted in ISSUE with redirect_valid=1 → next cycle redirect_valid=0, busy=0, redirect_cnt=0, fetch_req_ready=1.
